// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronizes eight async lines, applies polarity and
// level/edge qualification, and presents an enabled, registered interrupt vector.
module ext_int_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  irq_raw,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [7:0]  ext_int,
  output logic        irq_any
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][7:0] sync_r;
  logic [7:0] enable_r;
  logic [7:0] mode_r;
  logic [7:0] pol_r;
  logic [7:0] pend_r;
  logic [7:0] act_d_r;
  logic [2:0] warm_r;
  logic [7:0] ext_int_r;

  logic [7:0] irq_s;
  logic [7:0] wdata_s;
  logic       wr_enable_s;
  logic       wr_mode_s;
  logic       wr_pol_s;
  logic       wr_pend_s;
  logic [7:0] mode_next_s;
  logic [7:0] pol_next_s;
  logic [7:0] chg_s;
  logic [7:0] act_s;
  logic [7:0] clr_s;
  logic [7:0] edge_set_s;
  logic       warm_done_s;
  logic [7:0] pend_next_s;
  logic [7:0] rd_byte_s;

  assign irq_s       = sync_r[SYNC_STAGES-1];
  assign wdata_s     = cfg_wdata[7:0];
  assign warm_done_s = (warm_r == WARM_MAX);

  // Config write decode and next-state of the pending vector
  always_comb begin
    wr_enable_s = cfg_we && (cfg_addr == 3'd0);
    wr_mode_s   = cfg_we && (cfg_addr == 3'd1);
    wr_pol_s    = cfg_we && (cfg_addr == 3'd2);
    wr_pend_s   = cfg_we && (cfg_addr == 3'd3);
    if (wr_mode_s) begin
      mode_next_s = wdata_s;
    end else begin
      mode_next_s = mode_r;
    end
    if (wr_pol_s) begin
      pol_next_s = wdata_s;
    end else begin
      pol_next_s = pol_r;
    end
    if (wr_pend_s) begin
      clr_s = wdata_s;
    end else begin
      clr_s = 8'h00;
    end
    // Bits whose mode or polarity changes this cycle are re-armed without an edge
    chg_s       = (mode_next_s ^ mode_r) | (pol_next_s ^ pol_r);
    act_s       = irq_s ^ pol_r;
    edge_set_s  = act_s & ~act_d_r & mode_r & ~chg_s & {8{warm_done_s}};
    pend_next_s = ((~mode_r & act_s) | (mode_r & ((pend_r & ~clr_s) | edge_set_s))) & ~chg_s;
  end

  // Synchronizers, configuration, edge history and interrupt state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r    <= '0;
      enable_r  <= 8'h00;
      mode_r    <= 8'h00;
      pol_r     <= 8'h00;
      pend_r    <= 8'h00;
      act_d_r   <= 8'h00;
      warm_r    <= 3'd0;
      ext_int_r <= 8'h00;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], irq_raw};
      mode_r    <= mode_next_s;
      pol_r     <= pol_next_s;
      act_d_r   <= irq_s ^ pol_next_s;
      pend_r    <= pend_next_s;
      ext_int_r <= pend_r & enable_r;
      if (wr_enable_s) begin
        enable_r <= wdata_s;
      end else begin
        enable_r <= enable_r;
      end
      // Edges are not trusted until the chain has refilled after reset
      if (!warm_done_s) begin
        warm_r <= warm_r + 3'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  // Combinational register read-back
  always_comb begin
    case (cfg_addr)
      3'd0:    rd_byte_s = enable_r;
      3'd1:    rd_byte_s = mode_r;
      3'd2:    rd_byte_s = pol_r;
      3'd3:    rd_byte_s = pend_r;
      3'd4:    rd_byte_s = irq_s;
      default: rd_byte_s = 8'h00;
    endcase
  end

  assign cfg_rdata = {24'h000000, rd_byte_s};
  assign ext_int   = ext_int_r;
  assign irq_any   = |ext_int_r;

endmodule
